saturn_bus_config_arbiter: RTL and testbench

//  Memory-controller configuration and arbitration for the Saturn bus.
//  - Tracks the CONFIG/UNCNFG/RESET daisy chain for N memory-mapped modules (ROM, RAM, cards, I/O).
//  - Decodes each access address to one owning module and muxes that module's nibble back to the
//    bus controller's nibble input.
//  - Sits in saturn_bus between the module instances and saturn_bus_controller. It replaces the

---
 rtl/saturn_bus_pkg.sv | 19 +
 rtl/saturn_bus_cfg_slot.sv | 68 ++++++
 rtl/saturn_bus_config_arbiter.sv | 122 ++++++++++++
 tb/tb_saturn_bus_config_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_bus_pkg.sv
// Shared encodings for the Saturn bus configuration daisy chain.
package saturn_bus_pkg;

  localparam int SATURN_ADDR_W = 20;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_CONFIG = 2'd1,
    CMD_UNCNFG = 2'd2,
    CMD_RESET  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_UNCFG      = 2'd0,
    ST_SIZED      = 2'd1,
    ST_CONFIGURED = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/saturn_bus_cfg_slot.sv
// One chained module's configuration: state, size mask and base address.
// Strobes arrive pre-qualified by the parent (clock enable and priority already applied).
module saturn_bus_cfg_slot
  import saturn_bus_pkg::*;
#(
  parameter int ADDR_W = SATURN_ADDR_W,
  parameter bit FIXED  = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_step_i,
  input  logic              uncfg_i,
  input  logic              rst_cmd_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
  output cfg_state_e        state_o,
  output logic              hit_o,
  output logic              take_config_o,
  output logic              uncfg_match_o
);

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Fixed slots never leave CONFIGURED and keep base 0 / mask 0 (whole space).
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    base_d  = base_q;
    if (!FIXED) begin
      if (rst_cmd_i || uncfg_i) begin
        state_d = ST_UNCFG;
      end else if (cfg_step_i) begin
        case (state_q)
          ST_UNCFG: begin
            mask_d  = cmd_addr_i;
            state_d = ST_SIZED;
          end
          ST_SIZED: begin
            base_d  = cmd_addr_i & mask_q;
            state_d = ST_CONFIGURED;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FIXED ? ST_CONFIGURED : ST_UNCFG;
      mask_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
    end
  end

  assign state_o       = state_q;
  assign hit_o         = (state_q == ST_CONFIGURED) && ((acc_addr_i & mask_q) == base_q);
  assign take_config_o = (state_q != ST_CONFIGURED);
  assign uncfg_match_o = !FIXED && (state_q == ST_CONFIGURED) &&
                         ((cmd_addr_i & mask_q) == base_q);

endmodule

// File: rtl/saturn_bus_config_arbiter.sv
// Saturn bus memory-controller configuration chain and access arbiter: dispatches
// CONFIG/UNCNFG/RESET to the chained slots and muxes the owning module's nibble.
module saturn_bus_config_arbiter
  import saturn_bus_pkg::*;
#(
  parameter int                     N_MODULES     = 4,
  parameter logic [N_MODULES-1:0]   FIXED_MODULES = 4'b0001,
  parameter int                     ADDR_W        = SATURN_ADDR_W
) (
  input  logic                   i_clk,
  input  logic                   i_clk_en,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  output logic                   o_cmd_done,
  output logic                   o_cmd_err,
  input  logic                   i_acc_valid,
  input  logic [ADDR_W-1:0]      i_acc_addr,
  output logic [N_MODULES-1:0]   o_sel,
  output logic                   o_hit,
  input  logic [4*N_MODULES-1:0] i_mod_nibbles,
  output logic [3:0]             o_nibble,
  output logic [2*N_MODULES-1:0] o_cfg_state
);

  logic [N_MODULES-1:0] hit, take_config, uncfg_match;
  logic [N_MODULES-1:0] cfg_pick, uncfg_pick, sel_d;
  logic                 cfg_found;
  logic                 fire;
  cmd_e                 cmd;
  logic                 err_d;
  logic [N_MODULES-1:0] sel_q;
  logic                 hit_q, done_q, err_q;

  assign cmd  = cmd_e'(i_cmd);
  assign fire = i_clk_en && i_cmd_valid;

  // CONFIG goes to the lowest unconfigured slot, UNCNFG to the highest matching one,
  // and an access belongs to the highest hitting slot.
  always_comb begin
    cfg_pick   = '0;
    cfg_found  = 1'b0;
    uncfg_pick = '0;
    sel_d      = '0;
    for (int i = 0; i < N_MODULES; i++) begin
      if (!cfg_found && take_config[i]) begin
        cfg_pick[i] = 1'b1;
        cfg_found   = 1'b1;
      end
      if (uncfg_match[i]) begin
        uncfg_pick    = '0;
        uncfg_pick[i] = 1'b1;
      end
      if (hit[i]) begin
        sel_d    = '0;
        sel_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = 1'b0;
    case (cmd)
      CMD_CONFIG: err_d = ~|take_config;
      CMD_UNCNFG: err_d = ~|uncfg_match;
      default:    err_d = 1'b0;
    endcase
  end

  for (genvar g = 0; g < N_MODULES; g++) begin : g_slot
    cfg_state_e slot_state;

    saturn_bus_cfg_slot #(
      .ADDR_W (ADDR_W),
      .FIXED  (FIXED_MODULES[g])
    ) u_slot (
      .clk_i         (i_clk),
      .reset_i       (i_reset),
      .cfg_step_i    (fire && (cmd == CMD_CONFIG) && cfg_pick[g]),
      .uncfg_i       (fire && (cmd == CMD_UNCNFG) && uncfg_pick[g]),
      .rst_cmd_i     (fire && (cmd == CMD_RESET)),
      .cmd_addr_i    (i_cmd_addr),
      .acc_addr_i    (i_acc_addr),
      .state_o       (slot_state),
      .hit_o         (hit[g]),
      .take_config_o (take_config[g]),
      .uncfg_match_o (uncfg_match[g])
    );

    assign o_cfg_state[2*g +: 2] = slot_state;
  end

  // Decode uses slot state before this edge's command, so a same-cycle command
  // only affects later accesses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_q  <= '0;
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (i_clk_en) begin
      sel_q  <= i_acc_valid ? sel_d : '0;
      hit_q  <= i_acc_valid && (|hit);
      done_q <= i_cmd_valid;
      err_q  <= i_cmd_valid && err_d;
    end
  end

  always_comb begin
    o_nibble = 4'h0;
    for (int i = 0; i < N_MODULES; i++) begin
      if (sel_q[i]) o_nibble = o_nibble | i_mod_nibbles[4*i +: 4];
    end
  end

  assign o_sel      = sel_q;
  assign o_hit      = hit_q;
  assign o_cmd_done = done_q;
  assign o_cmd_err  = err_q;

endmodule

// File: tb/tb_saturn_bus_config_arbiter.sv
// Directed bench for saturn_bus_config_arbiter with default parameters (module 0 fixed ROM).
module tb_saturn_bus_config_arbiter;

  logic        i_clk;
  logic        i_clk_en;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic [19:0] i_cmd_addr;
  logic        o_cmd_done;
  logic        o_cmd_err;
  logic        i_acc_valid;
  logic [19:0] i_acc_addr;
  logic [3:0]  o_sel;
  logic        o_hit;
  logic [15:0] i_mod_nibbles;
  logic [3:0]  o_nibble;
  logic [7:0]  o_cfg_state;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] C_NOP = 2'd0, C_CFG = 2'd1, C_UNC = 2'd2, C_RST = 2'd3;

  saturn_bus_config_arbiter dut (
    .i_clk         (i_clk),
    .i_clk_en      (i_clk_en),
    .i_reset       (i_reset),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .i_cmd_addr    (i_cmd_addr),
    .o_cmd_done    (o_cmd_done),
    .o_cmd_err     (o_cmd_err),
    .i_acc_valid   (i_acc_valid),
    .i_acc_addr    (i_acc_addr),
    .o_sel         (o_sel),
    .o_hit         (o_hit),
    .i_mod_nibbles (i_mod_nibbles),
    .o_nibble      (o_nibble),
    .o_cfg_state   (o_cfg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    i_clk_en = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [19:0] a);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    i_cmd_addr = a;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd = C_NOP;
    i_cmd_addr = '0;
  endtask

  task automatic do_acc(input logic [19:0] a);
    i_acc_valid = 1'b1;
    i_acc_addr = a;
    tick();
    i_acc_valid = 1'b0;
    i_acc_addr = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel actual=%b required=%b", o_sel, 4'b0000); end
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL reset_hit actual=%b required=0", o_hit); end
    checks++; if (o_cmd_done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", o_cmd_done); end
    checks++; if (o_cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err actual=%b required=0", o_cmd_err); end
    checks++; if (o_cfg_state !== 8'h02) begin errors++; $display("FAIL reset_state actual=%h required=02", o_cfg_state); end
    checks++; if (o_nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble actual=%h required=0", o_nibble); end
  endtask

  task automatic test_rom_fixed();
    do_acc(20'h12345);
    checks++; if (o_sel !== 4'b0001) begin errors++; $display("FAIL rom_sel actual=%b required=0001", o_sel); end
    checks++; if (o_hit !== 1'b1) begin errors++; $display("FAIL rom_hit actual=%b required=1", o_hit); end
    checks++; if (o_nibble !== 4'h3) begin errors++; $display("FAIL rom_nibble actual=%h required=3", o_nibble); end
    tick();
    checks++; if (o_sel !== 4'b0000 || o_hit !== 1'b0) begin errors++; $display("FAIL idle_sel actual=%b/%b required=0000/0", o_sel, o_hit); end
    checks++; if (o_nibble !== 4'h0) begin errors++; $display("FAIL idle_nibble actual=%h required=0", o_nibble); end
  endtask

  task automatic test_config_pair();
    apply_reset();
    do_cmd(C_CFG, 20'hF0000);
    checks++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b0) begin errors++; $display("FAIL cfg1_done actual=%b/%b required=1/0", o_cmd_done, o_cmd_err); end
    checks++; if (o_cfg_state !== 8'h06) begin errors++; $display("FAIL cfg1_state actual=%h required=06", o_cfg_state); end
    do_cmd(C_CFG, 20'h80000);
    checks++; if (o_cfg_state !== 8'h0A) begin errors++; $display("FAIL cfg2_state actual=%h required=0a", o_cfg_state); end
    tick();
    checks++; if (o_cmd_done !== 1'b0) begin errors++; $display("FAIL cfg_done_pulse actual=%b required=0", o_cmd_done); end
    do_acc(20'h8ABCD);
    checks++; if (o_sel !== 4'b0010) begin errors++; $display("FAIL cfg_sel_hi actual=%b required=0010", o_sel); end
    checks++; if (o_nibble !== 4'hA) begin errors++; $display("FAIL cfg_nibble actual=%h required=a", o_nibble); end
    do_acc(20'h7FFFF);
    checks++; if (o_sel !== 4'b0001) begin errors++; $display("FAIL cfg_sel_lo actual=%b required=0001", o_sel); end
  endtask

  task automatic test_config_full();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      do_cmd(C_CFG, 20'hF0000);
      do_cmd(C_CFG, 20'h80000 + (20'h10000 * k));
    end
    checks++; if (o_cfg_state !== 8'hAA) begin errors++; $display("FAIL full_state actual=%h required=aa", o_cfg_state); end
    for (int k = 0; k < 2; k++) begin
      do_cmd(C_CFG, 20'hC0000);
      checks++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b1) begin errors++; $display("FAIL full_err%0d actual=%b/%b required=1/1", k, o_cmd_done, o_cmd_err); end
      checks++; if (o_cfg_state !== 8'hAA) begin errors++; $display("FAIL full_state%0d actual=%h required=aa", k, o_cfg_state); end
    end
    do_acc(20'hA1234);
    checks++; if (o_sel !== 4'b1000) begin errors++; $display("FAIL full_sel actual=%b required=1000", o_sel); end
  endtask

  task automatic test_uncnfg();
    apply_reset();
    do_cmd(C_CFG, 20'hF0000);
    do_cmd(C_CFG, 20'h80000);
    do_cmd(C_CFG, 20'hF0000);
    do_cmd(C_CFG, 20'h80000);
    checks++; if (o_cfg_state !== 8'h2A) begin errors++; $display("FAIL unc_pre_state actual=%h required=2a", o_cfg_state); end
    do_acc(20'h80010);
    checks++; if (o_sel !== 4'b0100) begin errors++; $display("FAIL unc_sel_pre actual=%b required=0100", o_sel); end
    checks++; if (o_nibble !== 4'h5) begin errors++; $display("FAIL unc_nibble actual=%h required=5", o_nibble); end
    do_cmd(C_UNC, 20'h80010);
    checks++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b0) begin errors++; $display("FAIL unc_done actual=%b/%b required=1/0", o_cmd_done, o_cmd_err); end
    checks++; if (o_cfg_state !== 8'h0A) begin errors++; $display("FAIL unc_state actual=%h required=0a", o_cfg_state); end
    do_acc(20'h80010);
    checks++; if (o_sel !== 4'b0010) begin errors++; $display("FAIL unc_sel_post actual=%b required=0010", o_sel); end
    do_cmd(C_UNC, 20'h12345);
    checks++; if (o_cmd_err !== 1'b1) begin errors++; $display("FAIL unc_nomatch_err actual=%b required=1", o_cmd_err); end
    checks++; if (o_cfg_state !== 8'h0A) begin errors++; $display("FAIL unc_nomatch_state actual=%h required=0a", o_cfg_state); end
  endtask

  task automatic test_reset_mid_config();
    apply_reset();
    do_cmd(C_CFG, 20'h00000);
    checks++; if (o_cfg_state !== 8'h06) begin errors++; $display("FAIL mid_sized actual=%h required=06", o_cfg_state); end
    do_acc(20'h00000);
    checks++; if (o_sel !== 4'b0001) begin errors++; $display("FAIL sized_nohit actual=%b required=0001", o_sel); end
    i_acc_valid = 1'b1;
    i_acc_addr = 20'h00000;
    apply_reset();
    i_acc_valid = 1'b0;
    checks++; if (o_cfg_state !== 8'h02) begin errors++; $display("FAIL mid_rst_state actual=%h required=02", o_cfg_state); end
    checks++; if (o_sel !== 4'b0000) begin errors++; $display("FAIL mid_rst_sel actual=%b required=0000", o_sel); end
    do_cmd(C_CFG, 20'hF0000);
    checks++; if (o_cfg_state !== 8'h06) begin errors++; $display("FAIL mid_restart actual=%h required=06", o_cfg_state); end
    do_cmd(C_CFG, 20'h80000);
    do_cmd(C_RST, 20'h00000);
    checks++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b0) begin errors++; $display("FAIL rstcmd_done actual=%b/%b required=1/0", o_cmd_done, o_cmd_err); end
    checks++; if (o_cfg_state !== 8'h02) begin errors++; $display("FAIL rstcmd_state actual=%h required=02", o_cfg_state); end
    do_acc(20'h80000);
    checks++; if (o_sel !== 4'b0001) begin errors++; $display("FAIL rstcmd_sel actual=%b required=0001", o_sel); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    do_cmd(C_CFG, 20'hF0000);
    i_cmd_valid = 1'b1;
    i_cmd = C_CFG;
    i_cmd_addr = 20'h80000;
    i_acc_valid = 1'b1;
    i_acc_addr = 20'h80010;
    tick();
    i_cmd_valid = 1'b0;
    i_acc_valid = 1'b0;
    checks++; if (o_sel !== 4'b0001) begin errors++; $display("FAIL same_old_cfg actual=%b required=0001", o_sel); end
    checks++; if (o_cfg_state !== 8'h0A) begin errors++; $display("FAIL same_state actual=%h required=0a", o_cfg_state); end
    do_acc(20'h80010);
    checks++; if (o_sel !== 4'b0010) begin errors++; $display("FAIL same_new_cfg actual=%b required=0010", o_sel); end
  endtask

  task automatic test_clk_en();
    apply_reset();
    do_cmd(C_CFG, 20'hF0000);
    do_cmd(C_CFG, 20'h80000);
    i_cmd_valid = 1'b1;
    i_cmd = C_NOP;
    i_acc_valid = 1'b1;
    i_acc_addr = 20'h80010;
    tick();
    checks++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b0) begin errors++; $display("FAIL en_nop_done actual=%b/%b required=1/0", o_cmd_done, o_cmd_err); end
    checks++; if (o_sel !== 4'b0010) begin errors++; $display("FAIL en_sel actual=%b required=0010", o_sel); end
    i_clk_en = 1'b0;
    i_cmd = C_CFG;
    i_cmd_addr = 20'h00000;
    i_acc_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (o_sel !== 4'b0010 || o_hit !== 1'b1) begin errors++; $display("FAIL dis_hold%0d actual=%b/%b required=0010/1", k, o_sel, o_hit); end
      checks++; if (o_cfg_state !== 8'h0A) begin errors++; $display("FAIL dis_state%0d actual=%h required=0a", k, o_cfg_state); end
    end
    i_cmd_valid = 1'b0;
    i_clk_en = 1'b1;
    tick();
    checks++; if (o_sel !== 4'b0000 || o_hit !== 1'b0) begin errors++; $display("FAIL en_clear actual=%b/%b required=0000/0", o_sel, o_hit); end
    checks++; if (o_cmd_done !== 1'b0) begin errors++; $display("FAIL en_no_extra_done actual=%b required=0", o_cmd_done); end
    checks++; if (o_cfg_state !== 8'h0A) begin errors++; $display("FAIL en_ignored_cmd actual=%h required=0a", o_cfg_state); end
  endtask

  initial begin
    i_clk_en = 1'b1;
    i_reset = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd = C_NOP;
    i_cmd_addr = '0;
    i_acc_valid = 1'b0;
    i_acc_addr = '0;
    i_mod_nibbles = 16'hD5A3;
    test_reset();
    test_rom_fixed();
    test_config_pair();
    test_config_full();
    test_uncnfg();
    test_reset_mid_config();
    test_same_cycle();
    test_clk_en();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
